// File: rtl/bus_scenario_sequencer.sv
// bus_scenario_sequencer
// Table-driven bus stimulus sequencer. Scenario rows are written at run time
// through the cfg_* port (one master slot per write). A rising edge on start
// launches the row selected by state_in. The row's stimulus is driven on the
// master ports, enables are held for LAUNCH_CYCLES cycles, and the block then
// waits for every m_request to drop, giving up after TIMEOUT cycles.
//
// Ports:
//   clk, reset (async, active low)
//   start, state_in                  : launch request (rising edge) and row index
//   m_request                        : per-master busy/request
//   cfg_we, cfg_scen, cfg_master,
//   cfg_entry, cfg_ack               : table write port and acceptance pulse
//   m_enable, m_read_en, m_burst_mode,
//   m_addr, m_data                   : packed per-master stimulus, master i at
//                                      [i*W +: W]
//   busy, done, timeout, reject      : status level and result pulses
//   state_out                        : IDLE=0 LAUNCH=1 WAIT=2 DONE=3 TOUT=4
module bus_scenario_sequencer #(
    parameter int NUM_MASTERS   = 2,
    parameter int ADDR_WIDTH    = 14,
    parameter int DATA_WIDTH    = 8,
    parameter int BURST_WIDTH   = 3,
    parameter int NUM_SCEN      = 16,
    parameter int SCEN_WIDTH    = 5,
    parameter int LAUNCH_CYCLES = 3,
    parameter int TIMEOUT       = 255,
    localparam int CFG_MW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    localparam int ENTRY_W = 2 + BURST_WIDTH + ADDR_WIDTH + DATA_WIDTH
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [SCEN_WIDTH-1:0]              state_in,
    input  logic [NUM_MASTERS-1:0]             m_request,
    input  logic                               cfg_we,
    input  logic [SCEN_WIDTH-1:0]              cfg_scen,
    input  logic [CFG_MW-1:0]                  cfg_master,
    input  logic [ENTRY_W-1:0]                 cfg_entry,
    output logic                               cfg_ack,
    output logic [NUM_MASTERS-1:0]             m_enable,
    output logic [NUM_MASTERS-1:0]             m_read_en,
    output logic [NUM_MASTERS*BURST_WIDTH-1:0] m_burst_mode,
    output logic [NUM_MASTERS*ADDR_WIDTH-1:0]  m_addr,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]  m_data,
    output logic                               busy,
    output logic                               done,
    output logic                               timeout,
    output logic                               reject,
    output logic [2:0]                         state_out
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_TOUT   = 3'd4;

    localparam int SCEN_IW = (NUM_SCEN > 1) ? $clog2(NUM_SCEN) : 1;
    localparam int LCNT_W  = $clog2(LAUNCH_CYCLES + 1);
    localparam int WCNT_W  = $clog2(TIMEOUT + 1);

    // Entry field positions inside {enable, read, burst, addr, data}.
    localparam int F_ADDR  = DATA_WIDTH;
    localparam int F_BURST = DATA_WIDTH + ADDR_WIDTH;
    localparam int F_READ  = ENTRY_W - 2;
    localparam int F_EN    = ENTRY_W - 1;

    localparam logic [SCEN_WIDTH:0] NUM_SCEN_L    = (SCEN_WIDTH + 1)'(NUM_SCEN);
    localparam logic [CFG_MW:0]     NUM_MASTERS_L = (CFG_MW + 1)'(NUM_MASTERS);
    localparam logic [LCNT_W-1:0]   LAUNCH_LAST   = LCNT_W'(LAUNCH_CYCLES - 1);
    localparam logic [WCNT_W-1:0]   TIMEOUT_LAST  = WCNT_W'(TIMEOUT - 1);

    logic [ENTRY_W-1:0]    table_r [NUM_SCEN][NUM_MASTERS];
    logic [2:0]            state_r;
    logic                  start_q_r;
    logic [LCNT_W-1:0]     launch_cnt_r;
    logic [WCNT_W-1:0]     wait_cnt_r;

    logic                  start_edge_s;
    logic                  scen_ok_s;
    logic                  cfg_ok_s;
    logic                  launch_ok_s;
    logic [SCEN_IW-1:0]    run_idx_s;
    logic [SCEN_IW-1:0]    cfg_idx_s;
    logic [NUM_MASTERS-1:0] row_en_s;

    assign start_edge_s = start & ~start_q_r;
    assign run_idx_s    = state_in[SCEN_IW-1:0];
    assign cfg_idx_s    = cfg_scen[SCEN_IW-1:0];
    assign scen_ok_s    = ({1'b0, state_in} < NUM_SCEN_L);
    assign cfg_ok_s     = (state_r == ST_IDLE) && cfg_we
                          && ({1'b0, cfg_scen} < NUM_SCEN_L)
                          && ({1'b0, cfg_master} < NUM_MASTERS_L);
    assign launch_ok_s  = scen_ok_s && (|row_en_s);

    // Enable bits of the requested row; an out-of-range row reads as all-disabled.
    always_comb begin
        row_en_s = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (scen_ok_s) begin
                row_en_s[i] = table_r[run_idx_s][i][F_EN];
            end else begin
                row_en_s[i] = 1'b0;
            end
        end
    end

    // Scenario table, FSM, counters and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_SCEN; s++) begin
                for (int m = 0; m < NUM_MASTERS; m++) begin
                    table_r[s][m] <= '0;
                end
            end
            state_r      <= ST_IDLE;
            start_q_r    <= 1'b0;
            launch_cnt_r <= '0;
            wait_cnt_r   <= '0;
            cfg_ack      <= 1'b0;
            m_enable     <= '0;
            m_read_en    <= '0;
            m_burst_mode <= '0;
            m_addr       <= '0;
            m_data       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            reject       <= 1'b0;
        end else begin
            start_q_r <= start;
            cfg_ack   <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            reject    <= 1'b0;

            if (cfg_ok_s) begin
                table_r[cfg_idx_s][cfg_master] <= cfg_entry;
                cfg_ack <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    // A write in the same cycle takes priority over a launch.
                    if (start_edge_s) begin
                        if (cfg_we || !launch_ok_s) begin
                            reject <= 1'b1;
                        end else begin
                            state_r      <= ST_LAUNCH;
                            busy         <= 1'b1;
                            launch_cnt_r <= '0;
                            wait_cnt_r   <= '0;
                            for (int i = 0; i < NUM_MASTERS; i++) begin
                                m_enable[i]  <= table_r[run_idx_s][i][F_EN];
                                m_read_en[i] <= table_r[run_idx_s][i][F_READ];
                                m_burst_mode[i*BURST_WIDTH +: BURST_WIDTH] <=
                                    table_r[run_idx_s][i][F_BURST +: BURST_WIDTH];
                                m_addr[i*ADDR_WIDTH +: ADDR_WIDTH] <=
                                    table_r[run_idx_s][i][F_ADDR +: ADDR_WIDTH];
                                m_data[i*DATA_WIDTH +: DATA_WIDTH] <=
                                    table_r[run_idx_s][i][DATA_WIDTH-1:0];
                            end
                        end
                    end
                end
                ST_LAUNCH: begin
                    if (launch_cnt_r == LAUNCH_LAST) begin
                        state_r  <= ST_WAIT;
                        m_enable <= '0;
                    end else begin
                        launch_cnt_r <= launch_cnt_r + LCNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    // The counter freezes on the exit transition, so it never wraps.
                    if (m_request == '0) begin
                        state_r <= ST_DONE;
                        done    <= 1'b1;
                    end else if (wait_cnt_r == TIMEOUT_LAST) begin
                        state_r <= ST_TOUT;
                        timeout <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WCNT_W'(1);
                    end
                end
                ST_DONE, ST_TOUT: begin
                    state_r      <= ST_IDLE;
                    busy         <= 1'b0;
                    launch_cnt_r <= '0;
                    wait_cnt_r   <= '0;
                    m_enable     <= '0;
                    m_read_en    <= '0;
                    m_burst_mode <= '0;
                    m_addr       <= '0;
                    m_data       <= '0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    busy         <= 1'b0;
                    launch_cnt_r <= '0;
                    wait_cnt_r   <= '0;
                    m_enable     <= '0;
                    m_read_en    <= '0;
                    m_burst_mode <= '0;
                    m_addr       <= '0;
                    m_data       <= '0;
                end
            endcase
        end
    end

    assign state_out = state_r;

endmodule

// File: tb/tb_bus_scenario_sequencer.sv
// Self-checking bench for bus_scenario_sequencer. A table model and
// per-cycle expectations derived from launch/wait/timeout cycle arithmetic.
module tb_bus_scenario_sequencer;

    localparam int NM = 2;
    localparam int AW = 14;
    localparam int DW = 8;
    localparam int BW = 3;
    localparam int NS = 16;
    localparam int SW = 5;
    localparam int LC = 3;
    localparam int TO = 8;
    localparam int EW = 2 + BW + AW + DW;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [SW-1:0]     state_in;
    logic [NM-1:0]     m_request;
    logic              cfg_we;
    logic [SW-1:0]     cfg_scen;
    logic [0:0]        cfg_master;
    logic [EW-1:0]     cfg_entry;
    logic              cfg_ack;
    logic [NM-1:0]     m_enable;
    logic [NM-1:0]     m_read_en;
    logic [NM*BW-1:0]  m_burst_mode;
    logic [NM*AW-1:0]  m_addr;
    logic [NM*DW-1:0]  m_data;
    logic              busy;
    logic              done;
    logic              timeout;
    logic              reject;
    logic [2:0]        state_out;

    int tests  = 0;
    int failed = 0;
    logic [EW-1:0] mtab [NS][NM];

    always #5 clk = ~clk;

    bus_scenario_sequencer #(
        .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW),
        .NUM_SCEN(NS), .SCEN_WIDTH(SW), .LAUNCH_CYCLES(LC), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .state_in(state_in),
        .m_request(m_request), .cfg_we(cfg_we), .cfg_scen(cfg_scen),
        .cfg_master(cfg_master), .cfg_entry(cfg_entry), .cfg_ack(cfg_ack),
        .m_enable(m_enable), .m_read_en(m_read_en), .m_burst_mode(m_burst_mode),
        .m_addr(m_addr), .m_data(m_data), .busy(busy), .done(done),
        .timeout(timeout), .reject(reject), .state_out(state_out)
    );

    function automatic logic [EW-1:0] mk(input logic en, input logic rd, input int burst,
                                         input int addr, input int data);
        return {en, rd, BW'(burst), AW'(addr), DW'(data)};
    endfunction

    function automatic logic [63:0] obs_vec();
        return {2'b00, state_out, busy, done, timeout, reject, cfg_ack,
                m_enable, m_read_en, m_burst_mode, m_addr, m_data};
    endfunction

    // Expected output vector; ld selects whether row stimulus is on the ports.
    function automatic logic [63:0] exp_vec(input logic [2:0] st, input logic bsy,
                                            input logic dn, input logic to_p,
                                            input logic rj, input logic ak,
                                            input logic [1:0] en, input logic ld,
                                            input int row);
        logic [NM-1:0]    rd;
        logic [NM*BW-1:0] bu;
        logic [NM*AW-1:0] ad;
        logic [NM*DW-1:0] da;
        rd = '0; bu = '0; ad = '0; da = '0;
        if (ld) begin
            for (int i = 0; i < NM; i++) begin
                rd[i]            = mtab[row][i][EW-2];
                bu[i*BW +: BW]   = mtab[row][i][AW+DW +: BW];
                ad[i*AW +: AW]   = mtab[row][i][DW +: AW];
                da[i*DW +: DW]   = mtab[row][i][DW-1:0];
            end
        end
        return {2'b00, st, bsy, dn, to_p, rj, ak, en, rd, bu, ad, da};
    endfunction

    task automatic check(input string tag, input logic [63:0] expv);
        logic [63:0] o;
        o = obs_vec();
        tests++;
        assert (o === expv) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, o, expv);
        end
    endtask

    task automatic cfg_write(input int scen, input int mst, input logic [EW-1:0] e,
                             input logic with_start, input int srow);
        logic acc;
        acc = (scen < NS) && (mst < NM);
        @(negedge clk);
        cfg_we = 1'b1; cfg_scen = SW'(scen); cfg_master = 1'(mst); cfg_entry = e;
        if (with_start) begin
            start = 1'b1; state_in = SW'(srow);
        end
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0;
        if (acc) mtab[scen][mst] = e;
        check("cfg_ack", exp_vec(3'd0, 1'b0, 1'b0, 1'b0, with_start, acc, 2'b00, 1'b0, 0));
        @(negedge clk);
        check("cfg_ack_clr", exp_vec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0));
    endtask

    // Launch row; requests stay high for the first r WAIT cycles (rq=0 -> random).
    task automatic run_scen(input int row, input int r, input logic [1:0] rq_in,
                            input logic hold, input logic cfg_wait);
        logic [1:0] en;
        logic [1:0] rq;
        logic       ok;
        logic       tout;
        int         w;
        int         j;
        en   = (row < NS) ? {mtab[row][1][EW-1], mtab[row][0][EW-1]} : 2'b00;
        ok   = (row < NS) && (en != 2'b00);
        rq   = (rq_in != 2'b00) ? rq_in : 2'($urandom_range(1, 3));
        tout = (r >= TO);
        w    = tout ? TO : r + 1;
        @(negedge clk);
        start = 1'b1; state_in = SW'(row); m_request = rq;
        if (!ok) begin
            @(negedge clk);
            start = 1'b0;
            check("reject", exp_vec(3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 0));
            @(negedge clk);
            check("reject_clr", exp_vec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0));
            m_request = '0;
            return;
        end
        for (int c = 1; c <= LC + w + 1; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            cfg_we = 1'b0;
            if (c <= LC)
                check("launch", exp_vec(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, en, 1'b1, row));
            else if (c <= LC + w)
                check("wait", exp_vec(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, row));
            else if (tout)
                check("tout", exp_vec(3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, row));
            else
                check("done", exp_vec(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, row));
            j = c - LC - 1;
            m_request = (c <= LC || j < r) ? rq : 2'b00;
            if (cfg_wait && c == LC + 1) begin
                cfg_we = 1'b1; cfg_scen = SW'(row); cfg_master = 1'b0;
                cfg_entry = EW'($urandom);
            end
        end
        @(negedge clk);
        m_request = '0;
        check("idle_after", exp_vec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0));
        if (hold) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check("hold_no_rerun", exp_vec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0));
            end
            start = 1'b0;
        end
    endtask

    initial begin
        logic [EW-1:0] e0;
        logic [EW-1:0] e1;
        int            row;
        for (int s = 0; s < NS; s++) begin
            mtab[s][0] = '0; mtab[s][1] = '0;
        end
        reset = 1'b0; start = 1'b0; state_in = '0; m_request = '0;
        cfg_we = 1'b0; cfg_scen = '0; cfg_master = 1'b0; cfg_entry = '0;
        repeat (2) @(negedge clk);
        check("reset", 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle", 64'd0);

        // Single master, request already low at first WAIT cycle.
        cfg_write(1, 0, mk(1'b1, 1'b0, 0, 1365, 8'hAA), 1'b0, 0);
        run_scen(1, 0, 2'b00, 1'b0, 1'b0);

        // Dual master: requests high for 10 cycles from launch (7 WAIT cycles).
        cfg_write(7, 0, mk(1'b1, 1'b1, 0, 111, 0), 1'b0, 0);
        cfg_write(7, 1, mk(1'b1, 1'b0, 1, 1365, 8'h30), 1'b0, 0);
        run_scen(7, 7, 2'b11, 1'b0, 1'b0);

        // Drain timeout with a stuck request.
        cfg_write(2, 0, mk(1'b1, 1'b1, 5, 4000, 8'h5C), 1'b0, 0);
        run_scen(2, 20, 2'b01, 1'b0, 1'b0);

        // Rejections: out-of-range row, all-disabled row, start colliding with a write.
        run_scen(20, 0, 2'b00, 1'b0, 1'b0);
        cfg_write(5, 0, mk(1'b0, 1'b1, 3, 77, 8'h11), 1'b0, 0);
        cfg_write(5, 1, mk(1'b0, 1'b0, 2, 99, 8'h22), 1'b0, 0);
        run_scen(5, 0, 2'b00, 1'b0, 1'b0);
        cfg_write(17, 0, mk(1'b1, 1'b1, 7, 1, 1), 1'b0, 0);
        cfg_write(3, 1, mk(1'b1, 1'b1, 6, 16383, 8'hFF), 1'b1, 1);

        // Held start gives one run; a write during WAIT is ignored.
        run_scen(1, 2, 2'b00, 1'b1, 1'b0);
        run_scen(7, 3, 2'b00, 1'b0, 1'b1);
        run_scen(7, 1, 2'b00, 1'b0, 1'b0);

        // Randomized rows and drain lengths.
        for (int n = 0; n < 8; n++) begin
            row = $urandom_range(0, NS - 1);
            e0 = EW'($urandom);
            e1 = EW'($urandom);
            cfg_write(row, 0, e0, 1'b0, 0);
            cfg_write(row, 1, e1, 1'b0, 0);
            run_scen(row, $urandom_range(0, 10), 2'b00, 1'b0, 1'b0);
        end

        // Reset during the second LAUNCH cycle clears everything including the table.
        @(negedge clk);
        start = 1'b1; state_in = SW'(1);
        @(negedge clk);
        start = 1'b0;
        check("mid_launch1", exp_vec(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1));
        @(negedge clk);
        check("mid_launch2", exp_vec(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1));
        reset = 1'b0;
        #1;
        check("async_reset", 64'd0);
        for (int s = 0; s < NS; s++) begin
            mtab[s][0] = '0; mtab[s][1] = '0;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 64'd0);
        run_scen(1, 0, 2'b00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/bus_scenario_sequencer.md
Name: bus_scenario_sequencer

Overview:
- Parametrised, table-driven successor to the fixed-scenario bus test controller.
- Drives NUM_MASTERS master-port stimulus interfaces: enable, read_en, burst_mode, addr, data.
- Scenarios are loaded at run time into an internal table through a config port instead of being hard-coded.
- Adds rising-edge start, a request-drain timeout, invalid-scenario rejection, and completion/error pulses.

Parameters:
NUM_MASTERS, 2, number of master ports driven
ADDR_WIDTH, 14, address width per master
DATA_WIDTH, 8, data width per master
BURST_WIDTH, 3, burst_mode width per master
NUM_SCEN, 16, number of scenario table rows
SCEN_WIDTH, 5, width of scenario index inputs; NUM_SCEN <= 2**SCEN_WIDTH
LAUNCH_CYCLES, 3, cycles that enables stay asserted; >= 1
TIMEOUT, 255, maximum WAIT cycles before abort; >= 1

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  a rising edge requests execution of scenario state_in
state_in  in  SCEN_WIDTH  scenario index to run
m_request  in  NUM_MASTERS  per-master busy/request from the master ports
cfg_we  in  1  table write strobe
cfg_scen  in  SCEN_WIDTH  table row to write
cfg_master  in  clog2(NUM_MASTERS) (min 1)  master slot to write
cfg_entry  in  2+BURST_WIDTH+ADDR_WIDTH+DATA_WIDTH  {enable, read, burst, addr, data}, MSB first
cfg_ack  out  1  one-cycle pulse when a write is accepted
m_enable  out  NUM_MASTERS  per-master enable
m_read_en  out  NUM_MASTERS  per-master read enable
m_burst_mode  out  NUM_MASTERS*BURST_WIDTH  master i occupies bits [i*BURST_WIDTH +: BURST_WIDTH]
m_addr  out  NUM_MASTERS*ADDR_WIDTH  packed the same way
m_data  out  NUM_MASTERS*DATA_WIDTH  packed the same way
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse: scenario completed
timeout  out  1  one-cycle pulse: drain timed out
reject  out  1  one-cycle pulse: start refused
state_out  out  3  FSM state: IDLE=0, LAUNCH=1, WAIT=2, DONE=3, TOUT=4

Behaviour:
- Reset (async, low) clears to 0: every output, the FSM (IDLE), all counters, the start-edge register and every table entry.
- All outputs are registered.
- Start edge is detected as start & ~start_q, where start_q is registered every cycle. A held start never relaunches.
- Config writes:
  - Accepted only in IDLE with cfg_scen < NUM_SCEN and cfg_master < NUM_MASTERS.
  - On acceptance: entry written at the clock edge; cfg_ack high the following cycle.
  - Any other write is ignored and gives no ack.
- IDLE + start edge:
  - Row invalid (state_in >= NUM_SCEN) or all enable bits in the row 0: stay IDLE, reject pulses the next cycle.
  - Otherwise: go to LAUNCH, latch the row index, and at the same edge load every master's outputs from the table. m_enable[i] takes the entry's enable bit.
- A start edge coinciding with a cfg_we in IDLE: the config write wins; the start is rejected (reject pulse).
- LAUNCH:
  - Enables held for exactly LAUNCH_CYCLES cycles, counted by launch_cnt.
  - Then go to WAIT; m_enable clears at that edge.
  - read_en, burst_mode, addr and data hold until the return to IDLE.
- WAIT:
  - wait_cnt increments each cycle.
  - If m_request == 0: go to DONE.
  - Else if wait_cnt == TIMEOUT-1: go to TOUT.
  - Request low on the first WAIT cycle gives DONE after 1 cycle.
- DONE: done = 1 for one cycle, then IDLE.
- TOUT: timeout = 1 for one cycle, then IDLE.
- Entering IDLE clears m_read_en, m_burst_mode, m_addr, m_data and both counters.
- Start edges while busy are ignored; no reject is raised.
- Reset asserted mid-scenario returns immediately to IDLE with all outputs 0 and the table cleared.
- Masters with a 0 enable bit still take read/burst/addr/data from the table; their enable stays 0.
- Counters are sized clog2(max+1) and never wrap: wait_cnt stops at the TIMEOUT transition.

Test Plan:
- Reset and load: release reset; load row 1, master 0 = {en=1, rd=0, burst=0, addr=1365, data=0xAA}; start edge with state_in=1 -> cfg_ack one cycle after the write; m_enable=01 for 3 cycles; m_addr[13:0]=1365, m_data[7:0]=0xAA; m_request low -> done pulse, state_out returns to 0.
- Dual master: row 7 = master0 read addr 111, master1 burst 1 write addr 1365, data 0x30; m_request=11 for 10 cycles after LAUNCH -> both enables high 3 cycles; state_out=2 until requests drop; done exactly 1 cycle; no timeout.
- Timeout: TIMEOUT=8, m_request stuck at 01 -> state_out=4 after 8 WAIT cycles; timeout pulse; outputs cleared in IDLE.
- Rejection: start with state_in=20 (>= NUM_SCEN), then with an all-disabled row 5 -> reject pulse each time; busy stays 0; m_enable stays 0.
- Edge and busy rules: hold start high across scenario end -> exactly one run. cfg_we during WAIT -> no cfg_ack; table unchanged (rerun shows old data).
- Reset mid-op: assert reset during LAUNCH cycle 2 -> all outputs 0 asynchronously; state_out=0; a subsequent start on the old row is rejected (table cleared).
